// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// Signed operands are reduced to magnitudes on accept; the sign is re-applied as the product is stored.
module mult_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic [1:0]           dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never depends on ready, and in_ready/out_valid are pure decodes of the state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [2*WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]    mplier;
   logic                neg;
   logic [2*WIDTH-1:0]  acc;
   logic [CW-1:0]       cnt;

   logic [WIDTH-1:0]    a_abs;
   logic [WIDTH-1:0]    b_abs;
   logic [2*WIDTH-1:0]  addend;
   logic [2*WIDTH-1:0]  acc_sum;
   logic [2*WIDTH-1:0]  prod;
   logic                last_step;

   // The magnitude of the most negative value, 2^(WIDTH-1), still fits unsigned in WIDTH bits.
   assign a_abs     = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign b_abs     = (signed_mode && b[WIDTH-1]) ? -b : b;
   assign addend    = mplier[0] ? mcand : '0;
   assign acc_sum   = acc + addend;
   assign prod      = neg ? -acc_sum : acc_sum;
   assign last_step = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      dbg_state = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         p      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= {{WIDTH{1'b0}}, a_abs};
                  mplier <= b_abs;
                  neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               // p is written only here so it holds through DONE and after the handshake.
               if (last_step) begin
                  p <= prod;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed WIDTH=4 cases (latency, hold, reset abort, throughput)
// and random WIDTH=8 signed/unsigned traffic against a reference product.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid4, in_ready4, sm4, out_valid4, out_ready4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic [1:0]  dbg4;

   logic        in_valid8, in_ready8, sm8, out_valid8;
   logic        out_ready8 = 1'b0;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic [1:0]  dbg8;

   logic [7:0]  exp_q4[$];
   logic [15:0] exp_q8[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic rnd_on = 1'b0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       sm;
      logic [7:0] p;
   } vec4_t;

   vec4_t vecs[11];

   mult_seq #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
      .out_ready(out_ready4), .p(p4), .dbg_state(dbg4)
   );

   mult_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
      .out_ready(out_ready8), .p(p8), .dbg_state(dbg8)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_prod(input int w, input logic [15:0] av,
                                            input logic [15:0] bv, input logic sm);
      longint x, y, r;
      x = longint'(av);
      y = longint'(bv);
      if (sm && av[w-1]) x = x - (longint'(1) << w);
      if (sm && bv[w-1]) y = y - (longint'(1) << w);
      r = x * y;
      return 32'(r & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // scoreboard monitors: compare on every output handshake
   always @(negedge clk) begin
      if (rst_n && out_valid4 && out_ready4) begin
         if (exp_q4.size() == 0) check_eq("spurious_out4", 32'(out_valid4), 32'd0);
         else check_eq("p4", 32'(p4), 32'(exp_q4.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid8 && out_ready8) begin
         if (exp_q8.size() == 0) check_eq("spurious_out8", 32'(out_valid8), 32'd0);
         else check_eq("p8", 32'(p8), 32'(exp_q8.pop_front()));
      end
   end

   always @(posedge clk) begin
      #1;
      out_ready8 = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // driver tasks; all inputs change 1 time unit after a rising edge
   // Called 1 unit after the accept edge: counts edges from the accept edge (inclusive)
   // to the edge that raises out_valid, holds DONE, then handshakes.
   task automatic finish4(input logic [7:0] ev, input int hold);
      int n;
      n = 1;
      while (!out_valid4 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("latency4", 32'(n), 32'd5);
      for (int i = 0; i < hold; i++) begin
         check_eq("hold_valid", 32'(out_valid4), 32'd1);
         check_eq("hold_p", 32'(p4), 32'(ev));
         in_valid4 = (i % 2 == 0);
         a4 = 4'($urandom_range(0, 15));
         b4 = 4'($urandom_range(0, 15));
         sm4 = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      in_valid4 = 1'b1;
      a4 = 4'd6;
      b4 = 4'd6;
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      out_ready4 = 1'b0;
      check_eq("idle_after_hs", 32'(dbg4), 32'd0);
      check_eq("in_ready_after_hs", 32'(in_ready4), 32'd1);
      check_eq("out_valid_after_hs", 32'(out_valid4), 32'd0);
      check_eq("p_retained", 32'(p4), 32'(ev));
   endtask

   task automatic xact4(input logic [3:0] av, input logic [3:0] bv, input logic smv,
                        input logic [7:0] ev, input int hold);
      check_eq("in_ready_idle", 32'(in_ready4), 32'd1);
      a4 = av;
      b4 = bv;
      sm4 = smv;
      in_valid4 = 1'b1;
      out_ready4 = 1'b0;
      exp_q4.push_back(ev);
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      check_eq("dbg_run", 32'(dbg4), 32'd1);
      finish4(ev, hold);
   endtask

   task automatic xact8(input logic [7:0] av, input logic [7:0] bv, input logic smv);
      int guard;
      int n;
      guard = 0;
      while (!in_ready8 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      a8 = av;
      b8 = bv;
      sm8 = smv;
      in_valid8 = 1'b1;
      exp_q8.push_back(16'(ref_prod(8, 16'(av), 16'(bv), smv)));
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      n = 1;
      while (!out_valid8 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("latency8", 32'(n), 32'd9);
   endtask

   initial begin
      int guard;
      int last_cyc;
      vecs = '{
         '{4'd3,  4'd3,  1'b0, 8'd9},
         '{4'd15, 4'd15, 1'b0, 8'd225},
         '{4'd15, 4'd1,  1'b0, 8'd15},
         '{4'd1,  4'd2,  1'b0, 8'd2},
         '{4'd0,  4'd9,  1'b0, 8'd0},
         '{4'h8,  4'h8,  1'b1, 8'h40},
         '{4'hF,  4'd7,  1'b1, 8'hF9},
         '{4'd0,  4'h8,  1'b1, 8'h00},
         '{4'd7,  4'd7,  1'b1, 8'd49},
         '{4'h8,  4'd7,  1'b1, 8'hC8},
         '{4'hF,  4'hF,  1'b1, 8'h01}
      };
      rst_n = 1'b0;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; out_ready4 = 1'b0;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
      #3;
      check_eq("rst_in_ready", 32'(in_ready4), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid4), 32'd0);
      check_eq("rst_p4", 32'(p4), 32'd0);
      check_eq("rst_state", 32'(dbg4), 32'd0);
      check_eq("rst_p8", 32'(p8), 32'd0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed products, immediate handshake
      foreach (vecs[i]) xact4(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, 0);

      // backpressure: 10 cycles of out_ready=0 with in_valid pulses
      xact4(4'd13, 4'd11, 1'b0, 8'd143, 10);

      // reset two cycles into RUN aborts the product
      a4 = 4'd9; b4 = 4'd9; sm4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_eq("abort_out_valid", 32'(out_valid4), 32'd0);
      check_eq("abort_p", 32'(p4), 32'd0);
      check_eq("abort_in_ready", 32'(in_ready4), 32'd1);
      check_eq("abort_state", 32'(dbg4), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      a4 = 4'd5; b4 = 4'd3; sm4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
      exp_q4.push_back(8'd15);
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      check_eq("accept_first_edge", 32'(dbg4), 32'd1);
      finish4(8'd15, 0);

      // back-to-back with in_valid and out_ready held high
      out_ready4 = 1'b1;
      in_valid4 = 1'b1;
      last_cyc = 0;
      for (int k = 0; k < 5; k++) begin
         guard = 0;
         while (!in_ready4 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
         end
         a4 = 4'(k * 3 + 2);
         b4 = 4'(15 - k);
         sm4 = 1'b0;
         exp_q4.push_back(8'(ref_prod(4, 16'(a4), 16'(b4), 1'b0)));
         if (k > 0) check_eq("b2b_period", 32'(cyc - last_cyc), 32'd6);
         last_cyc = cyc;
         @(posedge clk); #1;
      end
      in_valid4 = 1'b0;
      guard = 0;
      while (exp_q4.size() != 0 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      out_ready4 = 1'b0;
      check_eq("q4_drained", 32'(exp_q4.size()), 32'd0);

      // WIDTH=8 random traffic, random output backpressure
      rnd_on = 1'b1;
      for (int i = 0; i < 1000; i++) xact8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 1000; i++) xact8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
      xact8(8'h80, 8'h80, 1'b1);
      xact8(8'hFF, 8'hFF, 1'b0);
      rnd_on = 1'b0;
      guard = 0;
      while (exp_q8.size() != 0 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      check_eq("q8_drained", 32'(exp_q8.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operands and mode valid this cycle.
REQ-005 in_ready  output  1  block can accept operands this cycle.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 signed_mode  input  1  1: a, b, p two's complement; 0: unsigned.
REQ-009 out_valid  output  1  p holds a completed product.
REQ-010 out_ready  input  1  consumer accepts p this cycle.
REQ-011 p  output  2*WIDTH  product.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE; no other reachable states.
REQ-013 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-014 Accept: a clock edge with state IDLE and in_valid=1 SHALL latch a, b and signed_mode, clear the accumulator and bit counter, and move to RUN.
REQ-015 IDLE with in_valid=0 SHALL stay IDLE; in_valid while not IDLE SHALL be ignored and SHALL NOT alter latched operands.
REQ-016 RUN SHALL perform one shift-add step per cycle (one multiplier bit per step, LSB first) for exactly WIDTH cycles, then move to DONE.
REQ-017 Latency: out_valid SHALL rise WIDTH+1 rising edges after the accept edge, i.e. the first edge after the last RUN cycle; fixed, independent of operand values.
REQ-018 Unsigned mode: p SHALL equal a*b, zero-extended to 2*WIDTH bits, exact for all inputs (max (2^WIDTH-1)^2 fits).
REQ-019 Signed mode: p SHALL equal the exact two's-complement product in 2*WIDTH bits, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2) and any operand equal to 0.
REQ-020 Signed handling SHALL use latched magnitudes plus a result sign fix-up applied within the same fixed latency; no extra cycles in signed mode.
REQ-021 p SHALL change only on the RUN->DONE edge; p SHALL be stable while out_valid=1 and out_ready=0 (backpressure, unbounded hold).
REQ-022 DONE with out_ready=1 SHALL move to IDLE on that edge; operands presented in that same cycle SHALL NOT be accepted (in_ready=0 in DONE).
REQ-023 After handshake, p SHALL retain the last product until the next RUN->DONE edge.
REQ-024 Minimum throughput: one product per WIDTH+2 cycles with out_ready held high.
REQ-025 Bit counter SHALL be ceil(log2(WIDTH+1)) bits, no wrap before WIDTH steps complete.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, force state IDLE, out_valid=0, in_ready=1, p=0, accumulator, counter and latched operands to 0.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation; no product SHALL be delivered for it after release.
REQ-028 First accept after rst_n release SHALL be possible on the first rising edge with rst_n=1.

Verification (WIDTH=4 unless stated)
REQ-029 Unsigned a=3, b=3, out_ready=1 -> out_valid rises 5 edges after accept, p=8'd9, then IDLE, in_ready=1.
REQ-030 Unsigned a=15, b=15 -> p=8'd225; a=15, b=1 -> p=8'd15; a=1, b=2 -> p=8'd2; back-to-back with in_valid held high, one product per 6 cycles.
REQ-031 Signed a=4'b1000, b=4'b1000 -> p=8'h40; a=4'hF, b=4'd7 -> p=8'hF9; a=4'd0, b=4'b1000 -> p=8'h00.
REQ-032 out_ready=0 for 10 cycles after out_valid -> out_valid and p=product held constant throughout; in_valid pulses during that time ignored; out_ready=1 -> IDLE next edge.
REQ-033 rst_n pulsed low mid-RUN (2 cycles after accept) -> out_valid=0, p=0, in_ready=1 asynchronously; no out_valid afterwards until a new accept.
REQ-034 WIDTH=8 random unsigned and signed operands (>=1000 each) against a reference product -> all match, latency exactly 9 edges.
